// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the single-ported unified memory shared by
// instruction fetch (IF) and the data-memory stage (DM).
// Ports:
//   clk, reset                       clock, async active-high reset
//   if_req/if_addr                   fetch request and address
//   if_rdata/if_ready/if_stall       fetch data, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata    data request, store flag, addr, data
//   dm_rdata/dm_ready/dm_stall       load data, completion pulse, stall
//   mem_sel/mem_en/mem_we            mux select, access strobe, write enable
//   mem_addr/mem_wdata/mem_rdata     registered access address/data, read data
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_stall,
    output logic        mem_sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_DM
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_sel;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        w_busy;
    logic        w_first;
    logic        w_last;
    logic        w_grant_if;
    logic        w_grant_dm;

    assign w_busy  = (r_state != S_IDLE);
    assign w_first = w_busy && (r_cnt == LAT);
    assign w_last  = w_busy && (r_cnt == 4'd1);

    // The port finishing this cycle is left out of arbitration so that
    // continuous contention alternates between the two ports.
    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dm_req)
                    w_grant_dm = 1'b1;
                else if (if_req)
                    w_grant_if = 1'b1;
            end
            S_BUSY_IF: begin
                if (w_last) begin
                    if (dm_req)
                        w_grant_dm = 1'b1;
                    else
                        w_next = S_IDLE;
                end
            end
            S_BUSY_DM: begin
                if (w_last) begin
                    if (if_req)
                        w_grant_if = 1'b1;
                    else
                        w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_grant_dm)
            w_next = S_BUSY_DM;
        else if (w_grant_if)
            w_next = S_BUSY_IF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_grant_dm) begin
            r_cnt   <= LAT;
            r_sel   <= 1'b1;
            r_we    <= dm_we;
            r_addr  <= dm_addr;
            r_wdata <= dm_wdata;
        end else if (w_grant_if) begin
            r_cnt   <= LAT;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= if_addr;
        end else if (w_busy) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_last)
                r_we <= 1'b0;
        end
    end

    assign mem_sel   = r_sel;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_en    = w_first;

    assign if_ready = w_last && (r_state == S_BUSY_IF);
    assign dm_ready = w_last && (r_state == S_BUSY_DM);

    // Read data is forced to zero outside the ready pulse so idle/reset
    // outputs are quiet.
    assign if_rdata = if_ready ? mem_rdata : 32'd0;
    assign dm_rdata = dm_ready ? mem_rdata : 32'd0;

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// with MEM_LAT=2 and a memory that returns addr ^ 0xA5A50000.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_stall;
    logic        mem_sel;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests;
    int n_fail;

    mem_port_arbiter #(.MEM_LAT(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .dm_stall (dm_stall),
        .mem_sel  (mem_sel),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, " mem_sel"}, 32'(mem_sel), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " if_ready"}, 32'(if_ready), 32'd0);
        chk({tag, " dm_ready"}, 32'(dm_ready), 32'd0);
        chk({tag, " if_rdata"}, if_rdata, 32'd0);
        chk({tag, " dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'd0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'd0;
        dm_wdata = 32'd0;

        // reset
        #3;
        chk_quiet("rst");
        chk("rst if_stall", 32'(if_stall), 32'd0);
        chk("rst dm_stall", 32'(dm_stall), 32'd0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        tick;
        chk_quiet("post_rst");

        // single fetch: cycle 0
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        #1;
        chk("f0 if_stall", 32'(if_stall), 32'd1);
        tick;
        chk("f1 mem_en", 32'(mem_en), 32'd1);
        chk("f1 mem_sel", 32'(mem_sel), 32'd0);
        chk("f1 mem_addr", mem_addr, 32'h40);
        chk("f1 if_ready", 32'(if_ready), 32'd0);
        chk("f1 if_stall", 32'(if_stall), 32'd1);
        tick;
        chk("f2 if_ready", 32'(if_ready), 32'd1);
        chk("f2 if_rdata", if_rdata, 32'hA5A5_0040);
        chk("f2 mem_en", 32'(mem_en), 32'd0);
        chk("f2 if_stall", 32'(if_stall), 32'd0);
        if_req = 1'b0;
        tick;
        chk("f3 mem_en", 32'(mem_en), 32'd0);
        chk("f3 if_ready", 32'(if_ready), 32'd0);
        tick;

        // contention: DM first, then IF with no bubble
        if_req  = 1'b1;
        if_addr = 32'h40;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h100;
        #1;
        chk("c0 if_stall", 32'(if_stall), 32'd1);
        chk("c0 dm_stall", 32'(dm_stall), 32'd1);
        tick;
        chk("c1 mem_sel", 32'(mem_sel), 32'd1);
        chk("c1 mem_en", 32'(mem_en), 32'd1);
        chk("c1 mem_addr", mem_addr, 32'h100);
        chk("c1 mem_we", 32'(mem_we), 32'd0);
        chk("c1 if_stall", 32'(if_stall), 32'd1);
        tick;
        chk("c2 mem_sel", 32'(mem_sel), 32'd1);
        chk("c2 dm_ready", 32'(dm_ready), 32'd1);
        chk("c2 dm_rdata", dm_rdata, 32'hA5A5_0100);
        chk("c2 dm_stall", 32'(dm_stall), 32'd0);
        chk("c2 if_stall", 32'(if_stall), 32'd1);
        dm_req = 1'b0;
        tick;
        chk("c3 mem_en", 32'(mem_en), 32'd1);
        chk("c3 mem_sel", 32'(mem_sel), 32'd0);
        chk("c3 mem_addr", mem_addr, 32'h40);
        chk("c3 dm_ready", 32'(dm_ready), 32'd0);
        chk("c3 if_stall", 32'(if_stall), 32'd1);
        tick;
        chk("c4 if_ready", 32'(if_ready), 32'd1);
        chk("c4 if_rdata", if_rdata, 32'hA5A5_0040);
        chk("c4 if_stall", 32'(if_stall), 32'd0);
        if_req = 1'b0;
        tick;
        chk("c5 mem_en", 32'(mem_en), 32'd0);
        tick;

        // store
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h200;
        dm_wdata = 32'hDEAD_BEEF;
        tick;
        chk("s1 mem_en", 32'(mem_en), 32'd1);
        chk("s1 mem_we", 32'(mem_we), 32'd1);
        chk("s1 mem_sel", 32'(mem_sel), 32'd1);
        chk("s1 mem_addr", mem_addr, 32'h200);
        chk("s1 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s1 dm_ready", 32'(dm_ready), 32'd0);
        tick;
        chk("s2 dm_ready", 32'(dm_ready), 32'd1);
        chk("s2 mem_en", 32'(mem_en), 32'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick;
        chk("s3 mem_we", 32'(mem_we), 32'd0);
        chk("s3 mem_en", 32'(mem_en), 32'd0);
        chk("s3 mem_wdata hold", mem_wdata, 32'hDEAD_BEEF);
        chk("s3 mem_sel hold", 32'(mem_sel), 32'd1);
        chk("s3 dm_ready", 32'(dm_ready), 32'd0);
        tick;

        // fairness: both held, grants alternate DM, IF, ...
        if_req  = 1'b1;
        if_addr = 32'h40;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h100;
        for (int c = 1; c <= 12; c++) begin
            tick;
            begin
                int  g;
                logic dm_turn;
                g       = (c - 1) / 2;
                dm_turn = (g % 2) == 0;
                chk($sformatf("fair%0d mem_sel", c), 32'(mem_sel),
                    32'(dm_turn));
                chk($sformatf("fair%0d mem_en", c), 32'(mem_en),
                    32'(c % 2 == 1));
                chk($sformatf("fair%0d dm_ready", c), 32'(dm_ready),
                    32'(c % 2 == 0 && dm_turn));
                chk($sformatf("fair%0d if_ready", c), 32'(if_ready),
                    32'(c % 2 == 0 && !dm_turn));
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick;
        chk("fair_end mem_en", 32'(mem_en), 32'd0);
        tick;

        // reset during a DM load
        dm_req  = 1'b1;
        dm_addr = 32'h100;
        tick;
        chk("r1 mem_en", 32'(mem_en), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_quiet("r1 in_rst");
        chk("r1 dm_stall", 32'(dm_stall), 32'd1);
        dm_req = 1'b0;
        tick;
        chk("r2 dm_ready", 32'(dm_ready), 32'd0);
        tick;
        chk("r3 dm_ready", 32'(dm_ready), 32'd0);
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h80;
        tick;
        chk("r4 mem_en", 32'(mem_en), 32'd1);
        chk("r4 mem_sel", 32'(mem_sel), 32'd0);
        chk("r4 mem_addr", mem_addr, 32'h80);
        chk("r4 dm_ready", 32'(dm_ready), 32'd0);
        tick;
        chk("r5 if_ready", 32'(if_ready), 32'd1);
        chk("r5 if_rdata", if_rdata, 32'hA5A5_0080);
        chk("r5 dm_ready", 32'(dm_ready), 32'd0);
        if_req = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
